// File: rtl/ecdsa_lh_update.sv
// Pairs computed logic hashes with header metadata, runs one ECDSA verify at a time and writes passing entries to the LH table.
// Pair-to-write latency >= 3 cycles; request held until ecdsa_req_ready, ecdsa_lh_ready drops when the hash FIFO has < 2 free slots.
package ecdsa_lh_pkg;
  localparam int LOGIC_HASH_NBITS = 64;
  localparam int DATA_PATH_NBITS  = 128;
  localparam int FID_NBITS        = 8;
  localparam int SERIAL_NUM_NBITS = 16;
  localparam int SERIAL_NUM_POS   = 47;
  localparam int PPL_NBITS        = 4;
  localparam int PPL_POS          = 51;

  typedef struct packed {
    logic [FID_NBITS-1:0] fid;
    logic                 discard;
  } lh_ecdsa_meta_type;
endpackage

module ecdsa_lh_fifo #(
  parameter int W           = 8,
  parameter int DEPTH_NBITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [W-1:0]         din,
  input  logic                 pop,
  output logic [W-1:0]         dout,
  output logic [DEPTH_NBITS:0] count,
  output logic                 empty,
  output logic                 full,
  output logic                 ovf
);
  localparam logic [DEPTH_NBITS:0] DEPTH = {1'b1, {DEPTH_NBITS{1'b0}}};
  localparam logic [DEPTH_NBITS:0] ONE   = {{DEPTH_NBITS{1'b0}}, 1'b1};
  localparam logic [DEPTH_NBITS-1:0] PTR_ONE = {{(DEPTH_NBITS-1){1'b0}}, 1'b1};

  logic [W-1:0]           mem [(1<<DEPTH_NBITS)];
  logic [DEPTH_NBITS-1:0] wr_ptr, rd_ptr;
  logic                   do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~do_pop;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + ONE;
      else if (do_pop && !do_push) count <= count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module ecdsa_lh_update
  import ecdsa_lh_pkg::*;
#(
  parameter int DEPTH_NBITS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lh_ecdsa_hash_valid,
  input  logic [LOGIC_HASH_NBITS-1:0] lh_ecdsa_hash_data,
  input  logic                        lh_ecdsa_valid,
  input  logic [DATA_PATH_NBITS-1:0]  lh_ecdsa_hdr_data,
  input  lh_ecdsa_meta_type           lh_ecdsa_meta_data,
  input  logic                        lh_ecdsa_sop,
  input  logic                        lh_ecdsa_eop,
  output logic                        ecdsa_req_valid,
  output logic [LOGIC_HASH_NBITS-1:0] ecdsa_req_hash,
  input  logic                        ecdsa_req_ready,
  input  logic                        ecdsa_rsp_valid,
  input  logic                        ecdsa_rsp_pass,
  output logic                        ecdsa_lh_wr,
  output logic [FID_NBITS-1:0]        ecdsa_lh_waddr,
  output logic [LOGIC_HASH_NBITS-1:0] ecdsa_lh_wdata,
  output logic [SERIAL_NUM_NBITS-1:0] ecdsa_lh_sn_wdata,
  output logic [PPL_NBITS-1:0]        ecdsa_lh_ppl_wdata,
  output logic                        ecdsa_lh_ready,
  output logic [15:0]                 pass_cnt,
  output logic [15:0]                 fail_cnt,
  output logic                        err_ovf,
  output logic                        err_rsp
);
  typedef struct packed {
    logic [FID_NBITS-1:0]        fid;
    logic                        discard;
    logic [SERIAL_NUM_NBITS-1:0] sn;
    logic [PPL_NBITS-1:0]        ppl;
  } meta_entry_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WR} state_t;

  localparam logic [DEPTH_NBITS:0] DEPTH = {1'b1, {DEPTH_NBITS{1'b0}}};
  localparam logic [DEPTH_NBITS:0] TWO   = {{(DEPTH_NBITS-1){1'b0}}, 2'b10};

  state_t                      state_q, state_d;
  meta_entry_t                 meta_in, meta_head, pair_meta;
  logic [LOGIC_HASH_NBITS-1:0] hash_head, pair_hash;
  logic [DEPTH_NBITS:0]        hash_count, meta_count, hash_free;
  logic                        hash_empty, meta_empty, hash_full, meta_full;
  logic                        hash_ovf, meta_ovf, meta_push, pop;
  logic                        pass_inc, fail_inc, rsp_err;

  assign meta_push = lh_ecdsa_valid & lh_ecdsa_sop;
  assign meta_in   = '{fid:     lh_ecdsa_meta_data.fid,
                       discard: lh_ecdsa_meta_data.discard,
                       sn:      lh_ecdsa_hdr_data[SERIAL_NUM_POS -: SERIAL_NUM_NBITS],
                       ppl:     lh_ecdsa_hdr_data[PPL_POS -: PPL_NBITS]};

  ecdsa_lh_fifo #(.W(LOGIC_HASH_NBITS), .DEPTH_NBITS(DEPTH_NBITS)) u_hash_fifo (
    .clk(clk), .rst(rst), .push(lh_ecdsa_hash_valid), .din(lh_ecdsa_hash_data), .pop(pop),
    .dout(hash_head), .count(hash_count), .empty(hash_empty), .full(hash_full), .ovf(hash_ovf));

  ecdsa_lh_fifo #(.W($bits(meta_entry_t)), .DEPTH_NBITS(DEPTH_NBITS)) u_meta_fifo (
    .clk(clk), .rst(rst), .push(meta_push), .din(meta_in), .pop(pop),
    .dout(meta_head), .count(meta_count), .empty(meta_empty), .full(meta_full), .ovf(meta_ovf));

  assign hash_free      = DEPTH - hash_count;
  assign ecdsa_lh_ready = (hash_free >= TWO);

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    pass_inc = 1'b0;
    fail_inc = 1'b0;
    rsp_err  = ecdsa_rsp_valid & (state_q != WAIT);
    case (state_q)
      IDLE: if (!hash_empty && !meta_empty) begin
        pop = 1'b1;
        if (meta_head.discard) fail_inc = 1'b1;
        else                   state_d  = REQ;
      end
      REQ:  if (ecdsa_req_ready) state_d = WAIT;
      WAIT: if (ecdsa_rsp_valid) begin
        pass_inc = ecdsa_rsp_pass;
        fail_inc = ~ecdsa_rsp_pass;
        state_d  = ecdsa_rsp_pass ? WR : IDLE;
      end
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pair_hash <= '0;
      pair_meta <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err_ovf   <= 1'b0;
      err_rsp   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        pair_hash <= hash_head;
        pair_meta <= meta_head;
      end
      if (pass_inc && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
      if (fail_inc && fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
      if (hash_ovf || meta_ovf) err_ovf <= 1'b1;
      if (rsp_err)              err_rsp <= 1'b1;
    end
  end

  assign ecdsa_req_valid    = (state_q == REQ);
  assign ecdsa_req_hash     = pair_hash;
  assign ecdsa_lh_wr        = (state_q == WR);
  assign ecdsa_lh_waddr     = pair_meta.fid;
  assign ecdsa_lh_wdata     = pair_hash;
  assign ecdsa_lh_sn_wdata  = pair_meta.sn;
  assign ecdsa_lh_ppl_wdata = pair_meta.ppl;
endmodule

// File: tb/tb_ecdsa_lh_update.sv
// Directed bench with request/write scoreboards for ecdsa_lh_update.
module tb_ecdsa_lh_update;
  import ecdsa_lh_pkg::*;

  typedef struct {
    logic [FID_NBITS-1:0]        fid;
    logic [LOGIC_HASH_NBITS-1:0] hash;
    logic [SERIAL_NUM_NBITS-1:0] sn;
    logic [PPL_NBITS-1:0]        ppl;
  } wr_exp_t;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        lh_ecdsa_hash_valid = 1'b0;
  logic [LOGIC_HASH_NBITS-1:0] lh_ecdsa_hash_data = '0;
  logic                        lh_ecdsa_valid = 1'b0;
  logic [DATA_PATH_NBITS-1:0]  lh_ecdsa_hdr_data = '0;
  lh_ecdsa_meta_type           lh_ecdsa_meta_data = '0;
  logic                        lh_ecdsa_sop = 1'b0;
  logic                        lh_ecdsa_eop = 1'b0;
  logic                        ecdsa_req_valid;
  logic [LOGIC_HASH_NBITS-1:0] ecdsa_req_hash;
  logic                        ecdsa_req_ready = 1'b0;
  logic                        ecdsa_rsp_valid = 1'b0;
  logic                        ecdsa_rsp_pass = 1'b0;
  logic                        ecdsa_lh_wr;
  logic [FID_NBITS-1:0]        ecdsa_lh_waddr;
  logic [LOGIC_HASH_NBITS-1:0] ecdsa_lh_wdata;
  logic [SERIAL_NUM_NBITS-1:0] ecdsa_lh_sn_wdata;
  logic [PPL_NBITS-1:0]        ecdsa_lh_ppl_wdata;
  logic                        ecdsa_lh_ready;
  logic [15:0]                 pass_cnt, fail_cnt;
  logic                        err_ovf, err_rsp;

  ecdsa_lh_update #(.DEPTH_NBITS(2)) dut (
    .clk(clk), .rst(rst),
    .lh_ecdsa_hash_valid(lh_ecdsa_hash_valid), .lh_ecdsa_hash_data(lh_ecdsa_hash_data),
    .lh_ecdsa_valid(lh_ecdsa_valid), .lh_ecdsa_hdr_data(lh_ecdsa_hdr_data),
    .lh_ecdsa_meta_data(lh_ecdsa_meta_data), .lh_ecdsa_sop(lh_ecdsa_sop), .lh_ecdsa_eop(lh_ecdsa_eop),
    .ecdsa_req_valid(ecdsa_req_valid), .ecdsa_req_hash(ecdsa_req_hash), .ecdsa_req_ready(ecdsa_req_ready),
    .ecdsa_rsp_valid(ecdsa_rsp_valid), .ecdsa_rsp_pass(ecdsa_rsp_pass),
    .ecdsa_lh_wr(ecdsa_lh_wr), .ecdsa_lh_waddr(ecdsa_lh_waddr), .ecdsa_lh_wdata(ecdsa_lh_wdata),
    .ecdsa_lh_sn_wdata(ecdsa_lh_sn_wdata), .ecdsa_lh_ppl_wdata(ecdsa_lh_ppl_wdata),
    .ecdsa_lh_ready(ecdsa_lh_ready), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_ovf(err_ovf), .err_rsp(err_rsp));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int accepts = 0;
  int wr_seen = 0;
  logic [LOGIC_HASH_NBITS-1:0] exp_req[$];
  wr_exp_t                     exp_wr[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hash(input logic [LOGIC_HASH_NBITS-1:0] h);
    lh_ecdsa_hash_valid = 1'b1;
    lh_ecdsa_hash_data  = h;
    step();
    lh_ecdsa_hash_valid = 1'b0;
  endtask

  // Filler bits around sn/ppl make sure the fields are sliced from the right place.
  task automatic drive_hdr(input logic [FID_NBITS-1:0] fid, input logic discard,
                           input logic [SERIAL_NUM_NBITS-1:0] sn, input logic [PPL_NBITS-1:0] ppl);
    logic [DATA_PATH_NBITS-1:0] hdr;
    hdr = {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0};
    hdr[SERIAL_NUM_POS -: SERIAL_NUM_NBITS] = sn;
    hdr[PPL_POS -: PPL_NBITS] = ppl;
    lh_ecdsa_valid     = 1'b1;
    lh_ecdsa_sop       = 1'b1;
    lh_ecdsa_eop       = 1'b1;
    lh_ecdsa_hdr_data  = hdr;
    lh_ecdsa_meta_data = '{fid: fid, discard: discard};
  endtask

  task automatic send_hdr(input logic [FID_NBITS-1:0] fid, input logic discard,
                          input logic [SERIAL_NUM_NBITS-1:0] sn, input logic [PPL_NBITS-1:0] ppl);
    drive_hdr(fid, discard, sn, ppl);
    step();
    lh_ecdsa_valid = 1'b0;
    lh_ecdsa_sop   = 1'b0;
    lh_ecdsa_eop   = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    @(negedge clk);
    while (!ecdsa_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ecdsa_req_valid) chk("req_timeout", 128'd0, 128'd1);
  endtask

  // Holds ready low for `hold` cycles, accepts, then answers the verify one cycle into WAIT.
  task automatic serve(input logic pass, input int hold, input wr_exp_t e);
    int acc0;
    wait_req();
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {127'd0, ecdsa_req_valid}, 128'd1);
      chk("hold_hash", ecdsa_req_hash, e.hash);
      @(negedge clk);
    end
    acc0 = accepts;
    @(posedge clk); #1;
    ecdsa_req_ready = 1'b1;
    step();
    ecdsa_req_ready = 1'b0;
    chk("one_accept", accepts, acc0 + 1);
    chk("valid_drop", {127'd0, ecdsa_req_valid}, 128'd0);
    ecdsa_rsp_valid = 1'b1;
    ecdsa_rsp_pass  = pass;
    if (pass) exp_wr.push_back(e);
    step();
    ecdsa_rsp_valid = 1'b0;
    ecdsa_rsp_pass  = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ecdsa_req_valid && ecdsa_req_ready) begin
        accepts++;
        if (exp_req.size() == 0) chk("req_extra", 128'd1, 128'd0);
        else chk("req_hash", ecdsa_req_hash, exp_req.pop_front());
      end
      if (ecdsa_lh_wr) begin
        wr_exp_t e;
        wr_seen++;
        if (exp_wr.size() == 0) chk("wr_extra", 128'd1, 128'd0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", ecdsa_lh_waddr, e.fid);
          chk("wr_data", ecdsa_lh_wdata, e.hash);
          chk("wr_sn", ecdsa_lh_sn_wdata, e.sn);
          chk("wr_ppl", ecdsa_lh_ppl_wdata, e.ppl);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {127'd0, ecdsa_req_valid}, 128'd0);
    chk({tag, "_wr"}, {127'd0, ecdsa_lh_wr}, 128'd0);
    chk({tag, "_pass_cnt"}, pass_cnt, 128'd0);
    chk({tag, "_fail_cnt"}, fail_cnt, 128'd0);
    chk({tag, "_err_ovf"}, {127'd0, err_ovf}, 128'd0);
    chk({tag, "_err_rsp"}, {127'd0, err_rsp}, 128'd0);
    chk({tag, "_lh_ready"}, {127'd0, ecdsa_lh_ready}, 128'd1);
  endtask

  initial begin
    logic [LOGIC_HASH_NBITS-1:0] hs [5];
    wr_exp_t e;
    int w0, a0;

    // Reset values
    #2;
    chk_reset_outputs("rst");
    step();
    rst = 1'b0;
    step();

    // Basic pass
    e = '{fid: 8'd7, hash: 64'hA5A5_A5A5_A5A5_A5A5, sn: 16'h0012, ppl: 4'd3};
    exp_req.push_back(e.hash);
    lh_ecdsa_hash_valid = 1'b1;
    lh_ecdsa_hash_data  = e.hash;
    send_hdr(e.fid, 1'b0, e.sn, e.ppl);
    lh_ecdsa_hash_valid = 1'b0;
    serve(1'b1, 0, e);
    chk("basic_wr_count", wr_seen, 1);
    chk("basic_pass_cnt", pass_cnt, 128'd1);

    // Fail response: no write, fail_cnt increments
    exp_req.push_back(e.hash);
    send_hash(e.hash);
    send_hdr(e.fid, 1'b0, e.sn, e.ppl);
    serve(1'b0, 0, e);
    step();
    chk("fail_no_wr", wr_seen, 1);
    chk("fail_cnt1", fail_cnt, 128'd1);
    chk("fail_pass_cnt", pass_cnt, 128'd1);

    // Backpressure: request held for 10 cycles
    e = '{fid: 8'd2, hash: 64'h1111_2222_3333_4444, sn: 16'hBEEF, ppl: 4'hA};
    exp_req.push_back(e.hash);
    send_hash(e.hash);
    send_hdr(e.fid, 1'b0, e.sn, e.ppl);
    serve(1'b1, 10, e);
    chk("bp_wr_count", wr_seen, 2);

    // Overflow: 5 hashes, no headers
    for (int i = 0; i < 5; i++) begin
      hs[i] = 64'h0F00_0000_0000_0000 + 64'(i * 17 + 3);
      send_hash(hs[i]);
      if (i < 4) exp_req.push_back(hs[i]);
      if (i == 1) chk("ready_after2", {127'd0, ecdsa_lh_ready}, 128'd1);
      if (i == 2) chk("ready_after3", {127'd0, ecdsa_lh_ready}, 128'd0);
      if (i == 3) chk("no_ovf_at4", {127'd0, err_ovf}, 128'd0);
    end
    chk("ovf_set", {127'd0, err_ovf}, 128'd1);
    for (int j = 0; j < 4; j++) send_hdr(8'(10 + j), 1'b0, 16'(16'h0100 + j), 4'(j + 1));
    for (int j = 0; j < 4; j++) begin
      e = '{fid: 8'(10 + j), hash: hs[j], sn: 16'(16'h0100 + j), ppl: 4'(j + 1)};
      serve(1'b1, 0, e);
    end
    repeat (4) step();
    chk("ovf_wr_count", wr_seen, 6);
    chk("ovf_pass_cnt", pass_cnt, 128'd6);
    chk("ovf_no_5th", {127'd0, ecdsa_req_valid}, 128'd0);

    // Discard entry: no request, fail_cnt+1
    a0 = accepts;
    send_hash(64'hDDDD_0000_DDDD_0000);
    send_hdr(8'd9, 1'b1, 16'h0BAD, 4'd1);
    repeat (5) step();
    chk("disc_no_req", {127'd0, ecdsa_req_valid}, 128'd0);
    chk("disc_accepts", accepts, a0);
    chk("disc_fail_cnt", fail_cnt, 128'd2);

    // Spurious response in IDLE
    chk("rsp_err_clear", {127'd0, err_rsp}, 128'd0);
    ecdsa_rsp_valid = 1'b1;
    ecdsa_rsp_pass  = 1'b1;
    step();
    ecdsa_rsp_valid = 1'b0;
    ecdsa_rsp_pass  = 1'b0;
    step();
    chk("idle_err_rsp", {127'd0, err_rsp}, 128'd1);
    chk("idle_stays", {127'd0, ecdsa_req_valid}, 128'd0);
    chk("idle_pass_cnt", pass_cnt, 128'd6);

    // Reset while waiting for the verify result
    e = '{fid: 8'd5, hash: 64'h5555_6666_7777_8888, sn: 16'h0042, ppl: 4'd7};
    exp_req.push_back(e.hash);
    send_hash(e.hash);
    send_hdr(e.fid, 1'b0, e.sn, e.ppl);
    wait_req();
    @(posedge clk); #1;
    ecdsa_req_ready = 1'b1;
    step();
    ecdsa_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("wait_rst");
    step();
    rst = 1'b0;
    w0 = wr_seen;
    step();
    ecdsa_rsp_valid = 1'b1;
    ecdsa_rsp_pass  = 1'b1;
    step();
    ecdsa_rsp_valid = 1'b0;
    ecdsa_rsp_pass  = 1'b0;
    repeat (3) step();
    chk("late_rsp_err", {127'd0, err_rsp}, 128'd1);
    chk("late_no_wr", wr_seen, w0);
    chk("late_pass_cnt", pass_cnt, 128'd0);

    chk("req_queue_drained", exp_req.size(), 0);
    chk("wr_queue_drained", exp_wr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ecdsa_lh_update.md
ECDSA_LH_UPDATE -- requirements
Module: ecdsa_lh_update

Interface
REQ-001 SHALL have parameter: DEPTH_NBITS, 2, log2 depth of hash FIFO and meta FIFO (depth 4).
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock.
- `RESET_SIG  in  1  reset; asynchronous, active-high.
- lh_ecdsa_hash_valid  in  1  hash word strobe.
- lh_ecdsa_hash_data  in  `LOGIC_HASH_NBITS  computed logic hash.
- lh_ecdsa_valid  in  1  header beat strobe.
- lh_ecdsa_hdr_data  in  `DATA_PATH_NBITS  header beat.
- lh_ecdsa_meta_data  in  lh_ecdsa_meta_type  beat metadata (fid, discard used).
- lh_ecdsa_sop  in  1  first beat.
- lh_ecdsa_eop  in  1  last beat.
- ecdsa_req_valid  out  1  verify request valid.
- ecdsa_req_hash  out  `LOGIC_HASH_NBITS  hash to verify.
- ecdsa_req_ready  in  1  engine accepts request.
- ecdsa_rsp_valid  in  1  verify result strobe.
- ecdsa_rsp_pass  in  1  1 = signature valid.
- ecdsa_lh_wr  out  1  table write pulse.
- ecdsa_lh_waddr  out  `FID_NBITS  table address (fid).
- ecdsa_lh_wdata  out  `LOGIC_HASH_NBITS  hash to store.
- ecdsa_lh_sn_wdata  out  `SERIAL_NUM_NBITS  serial number to store.
- ecdsa_lh_ppl_wdata  out  `PPL_NBITS  PPL to store.
- ecdsa_lh_ready  out  1  hash FIFO has room for 2 or more entries.
- pass_cnt  out  16  saturating count of passed verifies.
- fail_cnt  out  16  saturating count of failed or discarded entries.
- err_ovf  out  1  sticky: push while FIFO full.
- err_rsp  out  1  sticky: response while not waiting.

Function
REQ-003 SHALL push lh_ecdsa_hash_data into the hash FIFO on each lh_ecdsa_hash_valid.
REQ-004 SHALL push {fid, discard, sn, ppl} into the meta FIFO on each lh_ecdsa_valid&lh_ecdsa_sop:
- sn = hdr_data[`SERIAL_NUM_POS -: `SERIAL_NUM_NBITS].
- ppl = hdr_data[`PPL_POS -: `PPL_NBITS].
- Non-sop beats are ignored.
REQ-005 SHALL, on a push to a full FIFO, drop the entry, leave FIFO contents unchanged and set err_ovf.
REQ-006 SHALL drive ecdsa_lh_ready = (hash FIFO free entries >= 2), combinationally from the FIFO count.
REQ-007 SHALL implement FSM IDLE, REQ, WAIT, WR. Reset state is IDLE.
REQ-008 IDLE: when both FIFOs are non-empty, pop both into pair registers in the same cycle.
- Discard bit = 1: increment fail_cnt, stay IDLE.
- Discard bit = 0: go to REQ.
REQ-009 REQ: ecdsa_req_valid=1 and ecdsa_req_hash=paired hash, both held stable until ecdsa_req_valid&ecdsa_req_ready; then go to WAIT.
REQ-010 WAIT: on ecdsa_rsp_valid:
- pass=1: go to WR, increment pass_cnt.
- pass=0: go to IDLE, increment fail_cnt.
REQ-011 WR: assert ecdsa_lh_wr for exactly one cycle with waddr=fid, wdata=hash, sn, ppl from the pair registers; then go to IDLE.
- Write occurs 1 cycle after the passing response.
REQ-012 SHALL allow at most one outstanding request.
- Minimum pair-to-write latency: 3 cycles (IDLE pop, REQ with ready=1, WAIT with rsp the same cycle as entry is not allowed; rsp is sampled from the WAIT cycle onward).
REQ-013 ecdsa_rsp_valid in IDLE, REQ or WR SHALL be ignored and SHALL set err_rsp.
REQ-014 Simultaneous push and pop on the same FIFO SHALL both take effect.
- When full, push with simultaneous pop is accepted and does not set err_ovf.
REQ-015 Hash and meta entries SHALL pair strictly in FIFO order; an unpaired entry waits indefinitely for its partner.
REQ-016 pass_cnt and fail_cnt SHALL saturate at 16'hFFFF.
REQ-017 ecdsa_lh_waddr, ecdsa_lh_wdata, ecdsa_lh_sn_wdata and ecdsa_lh_ppl_wdata are don't-care when ecdsa_lh_wr=0.

Reset
REQ-018 Asserting `RESET_SIG SHALL, asynchronously:
- empty both FIFOs, FSM to IDLE.
- ecdsa_req_valid=0, ecdsa_lh_wr=0, pass_cnt=0, fail_cnt=0, err_ovf=0, err_rsp=0.
- ecdsa_lh_ready=1.
REQ-019 Reset mid-request SHALL abandon the request; any response after reset release counts as spurious (err_rsp=1).

Verification
REQ-020 Basic pass: hash 0xA5.., sop with fid=7, sn=0x12, ppl=3; ready=1; rsp pass=1 two cycles later -> one ecdsa_lh_wr with waddr=7, wdata=0xA5.., sn_wdata=0x12, ppl_wdata=3; pass_cnt=1.
REQ-021 Fail: same stimulus with rsp pass=0 -> no ecdsa_lh_wr; fail_cnt=1.
REQ-022 Backpressure: ecdsa_req_ready=0 for 10 cycles -> ecdsa_req_valid and ecdsa_req_hash held constant for all 10 cycles; exactly one accept on the first cycle ready=1.
REQ-023 Overflow: 5 hashes, no headers -> 5th dropped; err_ovf=1; ecdsa_lh_ready=0 after 3rd push; then 4 headers -> 4 requests in order.
REQ-024 Discard and spurious:
- meta with discard=1 -> no request; fail_cnt+1.
- rsp_valid in IDLE -> err_rsp=1; FSM remains IDLE.
REQ-025 Reset in WAIT -> all outputs at reset values; a later rsp sets err_rsp; no write occurs.
